dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array, successor to the fixed 2-way dcache SRAM. It adds:
- explicit valid and dirty bits;
- true LRU state per set, instead of a single shared bit;
- invalid-first victim selection;
- a sequential flush/invalidate engine that streams dirty lines out over a valid/ready writeback handshake.

It sits between the dcache controller and the memory interface and keeps the same combinational read / clocked write access model.

---
 rtl/dcache_sram_nway.sv | 215 +++++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway
//   N-way set-associative data-cache storage with per-line valid/dirty bits,
//   true-LRU ages per set, invalid-first victim choice and a flush engine
//   that walks every (set, way) and streams dirty lines out for writeback.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   addr_i, tag_i, data_i        set index, lookup/write tag, write line
//   enable_i, write_i, dirty_i   access request, write/lookup, dirty on write
//   hit_o, way_o                 hit flag; hit way on hit, victim way on miss
//   tag_o, data_o                tag and line stored in way_o
//   valid_o, dirty_o             valid and dirty bits of way_o
//   flush_i, inv_i               start sweep; invalidate every line as well
//   busy_o, flush_done_o         sweep running; one-cycle end-of-sweep pulse
//   wb_valid_o, wb_ready_i       writeback handshake
//   wb_set_o, wb_tag_o, wb_data_o  line offered for writeback
module dcache_sram_nway #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 4,
    parameter int TAG_W    = 23,
    parameter int LINE_W   = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [SET_BITS-1:0]         addr_i,
    input  logic [TAG_W-1:0]            tag_i,
    input  logic [LINE_W-1:0]           data_i,
    input  logic                        enable_i,
    input  logic                        write_i,
    input  logic                        dirty_i,
    output logic                        hit_o,
    output logic [$clog2(WAYS)-1:0]     way_o,
    output logic [TAG_W-1:0]            tag_o,
    output logic [LINE_W-1:0]           data_o,
    output logic                        valid_o,
    output logic                        dirty_o,
    input  logic                        flush_i,
    input  logic                        inv_i,
    output logic                        busy_o,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [SET_BITS-1:0]         wb_set_o,
    output logic [TAG_W-1:0]            wb_tag_o,
    output logic [LINE_W-1:0]           wb_data_o,
    output logic                        flush_done_o
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int SETS     = 2 ** SET_BITS;

    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];
    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic [WAY_BITS-1:0] age_q   [SETS][WAYS];

    state_t              state_q;
    logic                inv_q;
    logic [SET_BITS-1:0] set_cnt_q, set_cnt_d;
    logic [WAY_BITS-1:0] way_cnt_q, way_cnt_d;
    logic                busy_q, wb_valid_q, flush_done_q;

    logic                acc, hit, victim_found;
    logic [WAY_BITS-1:0] hit_way, victim, way_sel;
    logic                cur_valid, cur_dirty, last_entry, scan_step, wb_fire;

    // Lookup: accesses are blocked while a sweep owns the array.
    always_comb begin
        acc          = enable_i && !busy_q;
        hit          = 1'b0;
        hit_way      = '0;
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (acc && valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        // Fill holes before evicting; otherwise evict the oldest way.
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[addr_i][w]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[addr_i][w] == WAY_BITS'(WAYS - 1)) begin
                    victim = WAY_BITS'(w);
                end
            end
        end
        way_sel = hit ? hit_way : victim;
    end

    assign hit_o   = hit;
    assign way_o   = way_sel;
    assign tag_o   = tag_q[addr_i][way_sel];
    assign data_o  = data_q[addr_i][way_sel];
    assign valid_o = valid_q[addr_i][way_sel];
    assign dirty_o = dirty_q[addr_i][way_sel];

    // Sweep cursor: way is the inner loop, set the outer loop.
    assign cur_valid  = valid_q[set_cnt_q][way_cnt_q];
    assign cur_dirty  = dirty_q[set_cnt_q][way_cnt_q];
    assign last_entry = (set_cnt_q == SET_BITS'(SETS - 1)) && (way_cnt_q == WAY_BITS'(WAYS - 1));
    assign scan_step  = (state_q == SCAN) && !(cur_valid && cur_dirty);
    assign wb_fire    = (state_q == WB) && wb_valid_q && wb_ready_i;
    assign way_cnt_d  = way_cnt_q + 1'b1;
    assign set_cnt_d  = (way_cnt_q == WAY_BITS'(WAYS - 1)) ? set_cnt_q + 1'b1 : set_cnt_q;

    assign busy_o       = busy_q;
    assign wb_valid_o   = wb_valid_q;
    assign flush_done_o = flush_done_q;
    assign wb_set_o     = set_cnt_q;
    assign wb_tag_o     = tag_q[set_cnt_q][way_cnt_q];
    assign wb_data_o    = data_q[set_cnt_q][way_cnt_q];

    // Storage array. Access writes only happen when idle and sweep writes only
    // when busy, so the two never target the array in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_BITS'(w);
                end
            end
        end else begin
            if (acc && write_i) begin
                tag_q[addr_i][way_sel]   <= tag_i;
                data_q[addr_i][way_sel]  <= data_i;
                valid_q[addr_i][way_sel] <= 1'b1;
                dirty_q[addr_i][way_sel] <= hit ? (dirty_q[addr_i][way_sel] | dirty_i) : dirty_i;
            end
            // Move the touched way to age 0; younger ways age by one, which
            // keeps the ages of a set a permutation of 0..WAYS-1.
            if (acc && (hit || write_i)) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_BITS'(w) == way_sel) begin
                        age_q[addr_i][w] <= '0;
                    end else if (age_q[addr_i][w] < age_q[addr_i][way_sel]) begin
                        age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
                    end
                end
            end
            if ((scan_step || wb_fire) && inv_q) begin
                valid_q[set_cnt_q][way_cnt_q] <= 1'b0;
            end
            if (wb_fire) begin
                dirty_q[set_cnt_q][way_cnt_q] <= 1'b0;
            end
        end
    end

    // Flush sweep controller with registered busy/writeback/done outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            inv_q        <= 1'b0;
            set_cnt_q    <= '0;
            way_cnt_q    <= '0;
            busy_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (flush_i) begin
                        inv_q     <= inv_i;
                        set_cnt_q <= '0;
                        way_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_valid && cur_dirty) begin
                        wb_valid_q <= 1'b1;
                        state_q    <= WB;
                    end else if (last_entry) begin
                        busy_q       <= 1'b0;
                        flush_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        way_cnt_q <= way_cnt_d;
                        set_cnt_q <= set_cnt_d;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        if (last_entry) begin
                            busy_q       <= 1'b0;
                            flush_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            way_cnt_q <= way_cnt_d;
                            set_cnt_q <= set_cnt_d;
                            state_q   <= SCAN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway
//   Self-checking bench for dcache_sram_nway built with four ways and 16 sets.
//   Access vectors come from a table; each driven vector is queued and checked
//   against the combinational outputs before the clock edge that commits it.
//   Flush, writeback stall and reset-abort sequences are written out by hand.
module tb_dcache_sram_nway;
    localparam int WAYS = 4, SET_BITS = 4, TAG_W = 23, LINE_W = 256;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [SET_BITS-1:0] addr_i;
    logic [TAG_W-1:0]    tag_i;
    logic [LINE_W-1:0]   data_i;
    logic                enable_i, write_i, dirty_i;
    logic                hit_o;
    logic [1:0]          way_o;
    logic [TAG_W-1:0]    tag_o;
    logic [LINE_W-1:0]   data_o;
    logic                valid_o, dirty_o;
    logic                flush_i, inv_i, busy_o;
    logic                wb_valid_o, wb_ready_i;
    logic [SET_BITS-1:0] wb_set_o;
    logic [TAG_W-1:0]    wb_tag_o;
    logic [LINE_W-1:0]   wb_data_o;
    logic                flush_done_o;

    dcache_sram_nway #(.WAYS(WAYS), .SET_BITS(SET_BITS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
        .enable_i(enable_i), .write_i(write_i), .dirty_i(dirty_i),
        .hit_o(hit_o), .way_o(way_o), .tag_o(tag_o), .data_o(data_o),
        .valid_o(valid_o), .dirty_o(dirty_o),
        .flush_i(flush_i), .inv_i(inv_i), .busy_o(busy_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_set_o(wb_set_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o),
        .flush_done_o(flush_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   st;
        logic         wr;
        logic [22:0]  tag;
        logic         dty;
        logic [255:0] din;
        logic         ehit;
        logic [1:0]   eway;
        logic [22:0]  etag;
        logic         evalid;
        logic         edirty;
        logic [255:0] edata;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[16];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic logic [255:0] ln(input logic [22:0] t);
        logic [31:0] w;
        w = {9'h0, t} ^ 32'h5A5A_0000;
        return {8{w}};
    endfunction

    function automatic vec_t mk(input logic [3:0] st, input logic wr, input logic [22:0] tag,
                                input logic dty, input logic [255:0] din, input logic ehit,
                                input logic [1:0] eway, input logic [22:0] etag,
                                input logic evalid, input logic edirty, input logic [255:0] edata);
        vec_t v;
        v.st = st; v.wr = wr; v.tag = tag; v.dty = dty; v.din = din;
        v.ehit = ehit; v.eway = eway; v.etag = etag; v.evalid = evalid;
        v.edirty = edirty; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one access after a rising edge; check it before the next one.
    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        @(posedge clk); #1;
        enable_i = 1'b1; write_i = v.wr; addr_i = v.st; tag_i = v.tag;
        dirty_i = v.dty; data_i = v.din;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({nm, " hit"},   hit_o,   e.ehit);
        chk({nm, " way"},   way_o,   e.eway);
        chk({nm, " tag"},   tag_o,   e.etag);
        chk({nm, " valid"}, valid_o, e.evalid);
        chk({nm, " dirty"}, dirty_o, e.edirty);
        chk({nm, " data"},  data_o,  e.edata);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        enable_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic start_flush(input logic inv);
        @(posedge clk); #1;
        flush_i = 1'b1; inv_i = inv;
        @(posedge clk); #1;
        flush_i = 1'b0; inv_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
    endtask

    task automatic wait_wb();
        int n = 0;
        while (!wb_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wb_valid wait", wb_valid_o, 1'b1);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_cyc, wb_seen, n;
        rst_i = 1'b1; addr_i = '0; tag_i = '0; data_i = '0; enable_i = 1'b0;
        write_i = 1'b0; dirty_i = 1'b0; flush_i = 1'b0; inv_i = 1'b0; wb_ready_i = 1'b0;

        // Reset state
        #2;
        chk("rst hit", hit_o, 1'b0);
        chk("rst way", way_o, 2'd0);
        chk("rst tag", tag_o, 23'd0);
        chk("rst data", data_o, 256'd0);
        chk("rst valid", valid_o, 1'b0);
        chk("rst dirty", dirty_o, 1'b0);
        chk("rst busy", busy_o, 1'b0);
        chk("rst wb_valid", wb_valid_o, 1'b0);
        chk("rst done", flush_done_o, 1'b0);
        #5 rst_i = 1'b0;

        // Clean-cache sweep: 64 busy cycles, done on the 65th
        start_flush(1'b0);
        busy_cnt = 0; done_cnt = 0; done_cyc = 0; wb_seen = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (flush_done_o) begin done_cnt++; done_cyc = c; end
            if (wb_valid_o) wb_seen++;
        end
        chk("empty flush busy cycles", busy_cnt, 64);
        chk("empty flush done cycle", done_cyc, 65);
        chk("empty flush done count", done_cnt, 1);
        chk("empty flush wb_valid", wb_seen, 0);

        // Fill, LRU victim, dirty merge and set isolation
        tbl[0]  = mk(3, 1, 23'h11, 0, ln(23'h11), 0, 0, 23'h00, 0, 0, 256'd0);
        tbl[1]  = mk(3, 1, 23'h22, 0, ln(23'h22), 0, 1, 23'h00, 0, 0, 256'd0);
        tbl[2]  = mk(3, 1, 23'h33, 0, ln(23'h33), 0, 2, 23'h00, 0, 0, 256'd0);
        tbl[3]  = mk(3, 1, 23'h44, 0, ln(23'h44), 0, 3, 23'h00, 0, 0, 256'd0);
        tbl[4]  = mk(3, 0, 23'h11, 0, 256'd0,     1, 0, 23'h11, 1, 0, ln(23'h11));
        tbl[5]  = mk(3, 0, 23'h22, 0, 256'd0,     1, 1, 23'h22, 1, 0, ln(23'h22));
        tbl[6]  = mk(3, 1, 23'h55, 0, ln(23'h55), 0, 2, 23'h33, 1, 0, ln(23'h33));
        tbl[7]  = mk(3, 0, 23'h33, 0, 256'd0,     0, 3, 23'h44, 1, 0, ln(23'h44));
        tbl[8]  = mk(3, 0, 23'h55, 0, 256'd0,     1, 2, 23'h55, 1, 0, ln(23'h55));
        tbl[9]  = mk(3, 1, 23'h11, 1, ln(23'h11), 1, 0, 23'h11, 1, 0, ln(23'h11));
        tbl[10] = mk(3, 1, 23'h11, 0, ln(23'h99), 1, 0, 23'h11, 1, 1, ln(23'h11));
        tbl[11] = mk(3, 0, 23'h11, 0, 256'd0,     1, 0, 23'h11, 1, 1, ln(23'h99));
        tbl[12] = mk(5, 1, 23'h66, 0, ln(23'h66), 0, 0, 23'h00, 0, 0, 256'd0);
        tbl[13] = mk(3, 0, 23'h77, 0, 256'd0,     0, 3, 23'h44, 1, 0, ln(23'h44));
        tbl[14] = mk(3, 0, 23'h44, 0, 256'd0,     1, 3, 23'h44, 1, 0, ln(23'h44));
        tbl[15] = mk(3, 0, 23'h77, 0, 256'd0,     0, 1, 23'h22, 1, 0, ln(23'h22));
        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));
        idle();

        // Dirty sweep with invalidate and a stalled consumer
        pulse_reset();
        apply(mk(2, 1, 23'hA0, 0, ln(23'hA0), 0, 0, 0, 0, 0, 256'd0), "fill s2w0");
        apply(mk(2, 1, 23'hA1, 1, ln(23'hA1), 0, 1, 0, 0, 0, 256'd0), "fill s2w1");
        apply(mk(9, 1, 23'hB0, 0, ln(23'hB0), 0, 0, 0, 0, 0, 256'd0), "fill s9w0");
        apply(mk(9, 1, 23'hB1, 0, ln(23'hB1), 0, 1, 0, 0, 0, 256'd0), "fill s9w1");
        apply(mk(9, 1, 23'hB2, 0, ln(23'hB2), 0, 2, 0, 0, 0, 256'd0), "fill s9w2");
        apply(mk(9, 1, 23'hB3, 1, ln(23'hB3), 0, 3, 0, 0, 0, 256'd0), "fill s9w3");
        idle();
        start_flush(1'b1);
        wait_wb();
        chk("wb1 set", wb_set_o, 4'd2);
        chk("wb1 tag", wb_tag_o, 23'hA1);
        chk("wb1 data", wb_data_o, ln(23'hA1));
        enable_i = 1'b1; write_i = 1'b0; addr_i = 4'd2; tag_i = 23'hA1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall wb_valid", wb_valid_o, 1'b1);
            chk("stall wb_set", wb_set_o, 4'd2);
            chk("stall wb_tag", wb_tag_o, 23'hA1);
            chk("stall wb_data", wb_data_o, ln(23'hA1));
            chk("stall busy", busy_o, 1'b1);
            chk("busy lookup hit", hit_o, 1'b0);
        end
        enable_i = 1'b0;
        wb_ready_i = 1'b1;
        @(posedge clk); #1 wb_ready_i = 1'b0;
        wait_wb();
        chk("wb2 set", wb_set_o, 4'd9);
        chk("wb2 tag", wb_tag_o, 23'hB3);
        chk("wb2 data", wb_data_o, ln(23'hB3));
        wb_ready_i = 1'b1;
        @(posedge clk); #1 wb_ready_i = 1'b0;
        n = 0;
        while (!flush_done_o && n < 200) begin
            @(negedge clk);
            chk("no third writeback", wb_valid_o, 1'b0);
            n++;
        end
        chk("inv flush done", flush_done_o, 1'b1);
        chk("inv flush busy low", busy_o, 1'b0);
        apply(mk(2, 0, 23'hA1, 0, 256'd0, 0, 0, 23'hA0, 0, 0, ln(23'hA0)), "post-inv s2 A1");
        apply(mk(2, 0, 23'hA0, 0, 256'd0, 0, 0, 23'hA0, 0, 0, ln(23'hA0)), "post-inv s2 A0");
        apply(mk(9, 0, 23'hB3, 0, 256'd0, 0, 0, 23'hB0, 0, 0, ln(23'hB0)), "post-inv s9 B3");
        apply(mk(9, 0, 23'hB1, 0, 256'd0, 0, 0, 23'hB0, 0, 0, ln(23'hB0)), "post-inv s9 B1");
        idle();

        // Reset while a writeback is pending
        apply(mk(0, 1, 23'h05, 1, ln(23'h05), 0, 0, 0, 0, 0, 256'd0), "fill s0w0");
        idle();
        start_flush(1'b0);
        wait_wb();
        rst_i = 1'b1;
        #1;
        chk("abort wb_valid", wb_valid_o, 1'b0);
        chk("abort busy", busy_o, 1'b0);
        #1 rst_i = 1'b0;
        apply(mk(0, 0, 23'h05, 0, 256'd0, 0, 0, 0, 0, 0, 256'd0), "post-rst s0");
        apply(mk(9, 0, 23'hB0, 0, 256'd0, 0, 0, 0, 0, 0, 256'd0), "post-rst s9");
        apply(mk(3, 0, 23'h00, 0, 256'd0, 0, 0, 0, 0, 0, 256'd0), "post-rst s3 tag0");
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
